// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO lands only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM and a byte FIFO with sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 217,
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rxd,
  input  logic      rd_en,
  output logic [7:0] rd_data,
  output logic      rd_valid,
  output logic      frame_err,
  output logic      overrun,
  input  logic      clr_err,
  output logic      rx_busy,
  output rx_state_t dbg_state
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(UART_DATA_BITS);

  logic [1:0]                sync_q;
  logic                      rxs;
  rx_state_t                 state_q;
  logic [CW-1:0]             cnt_q;
  logic [BW-1:0]             bit_idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      rx_busy_q;
  logic                      stop_hit;
  logic                      push_d;
  logic                      fifo_empty;
  logic                      fifo_full;

  assign rxs      = sync_q[1];
  assign stop_hit = (state_q == STOP) && (cnt_q == '0);
  // A full FIFO still accepts the byte when the reader frees a slot on the same edge.
  assign push_d   = stop_hit & rxs & (~fifo_full | rd_en);

  always_ff @(posedge clk) begin
    if (reset) sync_q <= {2{UART_IDLE_LEVEL}};
    else       sync_q <= {sync_q[0], rxd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      if (clr_err) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (state_q != IDLE && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_q   <= START;
            cnt_q     <= CW'(CLK_DIV/2 - 1);
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (rxs) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              cnt_q     <= CW'(CLK_DIV - 1);
            end
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shreg_q[bit_idx_q] <= rxs;
            bit_idx_q          <= bit_idx_q + BW'(1);
            cnt_q              <= CW'(CLK_DIV - 1);
            if (bit_idx_q == BW'(UART_DATA_BITS - 1)) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
            // Setting a flag overrides a clear arriving on the same edge.
            if (!rxs)                     frame_err_q <= 1'b1;
            else if (fifo_full && !rd_en) overrun_q   <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_d),
    .din   (shreg_q),
    .pop   (rd_en),
    .dout  (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rd_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = rx_busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random frames against a queue-based receive model.
module tb_uart_rx_fifo;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic reset;
  logic rxd;
  logic rd_en;
  logic clr_err;
  logic [7:0] rd_data;
  logic rd_valid;
  logic frame_err;
  logic overrun;
  logic rx_busy;
  uart_pkg::rx_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic exp_ferr;
  logic exp_ovr;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .rx_busy   (rx_busy),
    .dbg_state (dbg_state)
  );

  // All drivers start and end one time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rxd = 1'b0;
    step(CLK_DIV);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      step(CLK_DIV);
    end
    rxd = stop_ok;
    step(CLK_DIV);
    rxd = 1'b1;
    step(CLK_DIV);
    if (!stop_ok) step(2 * CLK_DIV);
  endtask

  // Receive model: a good frame queues the byte unless DEPTH bytes are held.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)                 exp_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                          exp_ovr = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rxd = 1'b1;
    rd_en = 1'b0;
    clr_err = 1'b0;
    step(3);
    reset = 1'b0;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 8'h00)  begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (rx_busy !== 1'b0)   begin bad++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_single();
    int n;
    n = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (n < 400 && !rd_valid) begin
          step(1);
          n++;
        end
      end
    join
    total++; if (n != 2 + 8 + 144 + 1) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n, 2 + 8 + 144 + 1); end
    total++; if (rd_data !== 8'hA5)  begin bad++; $display("FAIL single_data got=%h exp=a5", rd_data); end
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL single_flags got=%b%b exp=00", frame_err, overrun);
    end
    pop_one();
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL single_pop_empty got=%b exp=0", rd_valid); end
  endtask

  task automatic test_frame_err();
    send_byte(8'h55, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL ferr_no_push got=%b exp=0", rd_valid); end
    total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL ferr_overrun got=%b exp=0", overrun); end
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    rxd = 1'b0;
    step(5);
    rxd = 1'b1;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      step(1);
      if (rx_busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b1)    begin bad++; $display("FAIL glitch_busy_pulse got=%b exp=1", seen); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", rx_busy); end
    total++; if (rd_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL glitch_side_effects got=%b%b%b exp=000", rd_valid, frame_err, overrun);
    end
  endtask

  task automatic drain_and_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
        bad++; $display("FAIL %s_pop%0d got=%b/%h exp=1/%h", tag, i, rd_valid, rd_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pop_one();
    end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL %s_empty got=%b exp=0", tag, rd_valid); end
  endtask

  task automatic test_overrun();
    exp_q.delete();
    exp_ovr = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      send_byte(8'(b), 1'b1);
      model_frame(8'(b), 1'b1);
    end
    total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL ovr_set got=%b exp=%b", overrun, exp_ovr); end
    drain_and_check("ovr");
    for (int b = 8'h11; b <= 8'h14; b++) begin
      send_byte(8'(b), 1'b1);
      model_frame(8'(b), 1'b1);
    end
    // Pop lands in the stop-sample cycle of 0x06: stop sample is 155 edges after the start bit is driven.
    fork
      send_byte(8'h06, 1'b1);
      begin
        step(154);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h06);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL fullpop_overrun got=%b exp=1", overrun); end
    drain_and_check("fullpop");
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h3C;
    send_byte(8'h77, 1'b1);
    rxd = 1'b0;
    step(CLK_DIV);
    for (int k = 0; k < 3; k++) begin
      rxd = b[k];
      step(CLK_DIV);
    end
    rxd = b[3];
    step(CLK_DIV / 2);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL midreset_busy got=%b exp=1", rx_busy); end
    reset = 1'b1;
    rxd = 1'b1;
    step(2);
    reset = 1'b0;
    total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got=%b/%h/%b/%b/%b exp=0/00/0/0/0", rd_valid, rd_data, rx_busy, frame_err, overrun);
    end
    step(2 * CLK_DIV);
    send_byte(b, 1'b1);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      bad++; $display("FAIL midreset_next got=%b/%h exp=1/3c", rd_valid, rd_data);
    end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL midreset_ferr got=%b exp=0", frame_err); end
    pop_one();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic ok;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_byte(b, ok);
      model_frame(b, ok);
      e = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
      total++;
      if (rd_valid !== (exp_q.size() != 0) || rd_data !== e) begin
        bad++; $display("FAIL rand%0d_head got=%b/%h exp=%b/%h", i, rd_valid, rd_data, exp_q.size() != 0, e);
      end
      total++;
      if (frame_err !== exp_ferr || overrun !== exp_ovr) begin
        bad++; $display("FAIL rand%0d_flags got=%b%b exp=%b%b", i, frame_err, overrun, exp_ferr, exp_ovr);
      end
      if ($urandom_range(0, 2) == 0 && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pop_one();
      end
    end
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL rand_clear got=%b%b exp=00", frame_err, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
